// File: rtl/event_handshake_sender.sv
// Source side of a four-phase req/ack crossing: turns local event pulses into
// full handshakes on req_out, queueing events that arrive while one is in flight.
module event_handshake_sender #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             event_in,
    input  logic             ack_async,
    input  logic             clr_overflow,
    output logic             req_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ_HIGH = 2'd1,
        ST_REQ_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_ack_s1;
    logic             r_ack_s2;
    logic             r_req;
    logic             r_done;
    logic             r_overflow;
    logic [CNT_W-1:0] r_pending;

    logic             w_queued;
    logic             w_launch;
    logic             w_inc;
    logic             w_dec;
    logic             w_drop;
    logic             w_req_next;
    logic             w_done_next;
    logic             w_overflow_next;
    logic [CNT_W-1:0] w_pending_next;

    // Two-flop synchronizer; only r_ack_s2 may feed the control logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
        end else begin
            r_ack_s1 <= ack_async;
            r_ack_s2 <= r_ack_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_req      <= w_req_next;
            r_done     <= w_done_next;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign w_queued = (r_pending != '0);

    // A launch is refused while the synchronized ack is still high, so a stale
    // ack after reset cannot be mistaken for the answer to a new request.
    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_done_next  = 1'b0;
        w_launch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((event_in || w_queued) && !r_ack_s2) begin
                    w_launch     = 1'b1;
                    w_state_next = ST_REQ_HIGH;
                    w_req_next   = 1'b1;
                end
            end
            ST_REQ_HIGH: begin
                if (r_ack_s2) begin
                    w_state_next = ST_REQ_LOW;
                    w_req_next   = 1'b0;
                end
            end
            ST_REQ_LOW: begin
                if (!r_ack_s2) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    // A launch drains the queue first; only with an empty queue does it
    // consume the event arriving on the same cycle.
    assign w_dec = w_launch && w_queued;
    assign w_inc = event_in && !(w_launch && !w_queued);

    always_comb begin
        w_pending_next = r_pending;
        w_drop         = 1'b0;
        if (w_inc && !w_dec) begin
            if (r_pending == CNT_MAX) begin
                w_drop = 1'b1;
            end else begin
                w_pending_next = r_pending + CNT_ONE;
            end
        end else if (w_dec && !w_inc) begin
            w_pending_next = r_pending - CNT_ONE;
        end
    end

    always_comb begin
        w_overflow_next = r_overflow;
        if (w_drop) begin
            w_overflow_next = 1'b1;
        end else if (clr_overflow) begin
            w_overflow_next = 1'b0;
        end
    end

    assign req_out  = r_req;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_event_handshake_sender.sv
// Directed bench for event_handshake_sender: one DUT at CNT_W=4 for handshake
// scenarios and one at CNT_W=2 for counter saturation.
module tb_event_handshake_sender;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ev1, ack1, clr1;
    logic       req1, busy1, done1, ovf1;
    logic [3:0] pend1;
    logic       ev2, ack2, clr2;
    logic       req2, busy2, done2, ovf2;
    logic [1:0] pend2;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  max_pend = 0;
    int  ack_cnt  = 0;
    int  b2b_err  = 0;
    int  excl_err = 0;
    bit  auto_ack = 1'b0;
    logic       prev_done = 1'b0;
    logic [3:0] prev_pend = 4'd0;

    always #5 clk = ~clk;

    event_handshake_sender #(.CNT_W(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .event_in(ev1), .ack_async(ack1),
        .clr_overflow(clr1), .req_out(req1), .busy(busy1), .done(done1),
        .pending(pend1), .overflow(ovf1)
    );

    event_handshake_sender #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .event_in(ev2), .ack_async(ack2),
        .clr_overflow(clr2), .req_out(req2), .busy(busy2), .done(done2),
        .pending(pend2), .overflow(ovf2)
    );

    // One clock: sample 1 time unit after the edge, track handshake-level
    // properties, and optionally act as the foreign responder (2-cycle lag).
    task automatic step();
        @(posedge clk);
        #1;
        if (done1) done_cnt++;
        if (int'(pend1) > max_pend) max_pend = int'(pend1);
        if (done1 && (req1 || busy1)) excl_err++;
        if (prev_done && (prev_pend != 4'd0) && !req1) b2b_err++;
        prev_done = done1;
        prev_pend = pend1;
        if (auto_ack) begin
            if (ack1 != req1) begin
                ack_cnt++;
                if (ack_cnt >= 2) begin
                    ack1    = req1;
                    ack_cnt = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ack1 = i[0]; ev1 = ~i[0]; ack2 = ~i[0]; ev2 = i[0];
            step();
            n_checks++;
            if ({req1, busy1, done1, ovf1, pend1} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold_dut: outs=%h expected 00", {req1, busy1, done1, ovf1, pend1});
            end
            n_checks++;
            if ({req2, busy2, done2, ovf2, pend2} !== 6'h00) begin
                n_fail++;
                $display("FAIL reset_hold_sat: outs=%h expected 00", {req2, busy2, done2, ovf2, pend2});
            end
        end
        ack1 = 1'b0; ev1 = 1'b0; ack2 = 1'b0; ev2 = 1'b0;
        #2 reset_n = 1'b1;
        step(); step(); step();
        n_checks++;
        if ({req1, busy1, done1, ovf1, pend1} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: outs=%h expected 00", {req1, busy1, done1, ovf1, pend1});
        end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        done_cnt = 0;
        ev1 = 1'b1; step(); ev1 = 1'b0;
        n_checks++;
        if ({req1, busy1, pend1} !== 6'b11_0000) begin
            n_fail++;
            $display("FAIL single_launch: req/busy/pend=%b expected 110000", {req1, busy1, pend1});
        end
        step(); step();
        ack1 = 1'b1;
        step(); step();
        n_checks++;
        if (req1 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_req_hold: req_out=%b expected 1 two edges after ack", req1);
        end
        step();
        n_checks++;
        if ({req1, busy1} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_req_fall: req/busy=%b expected 01 three edges after ack", {req1, busy1});
        end
        step(); step(); step();
        ack1 = 1'b0;
        step(); step();
        n_checks++;
        if ({done1, busy1} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_pre_done: done/busy=%b expected 01", {done1, busy1});
        end
        step();
        n_checks++;
        if ({done1, busy1} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_done: done/busy=%b expected 10", {done1, busy1});
        end
        step();
        n_checks++;
        if ({done1, pend1} !== 5'b0_0000 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL single_end: done=%b pend=%0d done_cnt=%0d expected 0 0 1", done1, pend1, done_cnt);
        end
        $display("test_single: done pulses=%0d", done_cnt);
    endtask

    task automatic test_burst();
        done_cnt = 0; max_pend = 0; ack_cnt = 0; auto_ack = 1'b1;
        ev1 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ev1 = 1'b0;
        for (int i = 0; i < 300 && !(done_cnt == 5 && !busy1 && pend1 == 4'd0); i++) step();
        for (int i = 0; i < 5; i++) step();
        auto_ack = 1'b0;
        n_checks++;
        if (max_pend != 4) begin
            n_fail++;
            $display("FAIL burst_peak: peak pending=%0d expected 4", max_pend);
        end
        n_checks++;
        if (done_cnt != 5) begin
            n_fail++;
            $display("FAIL burst_done: done pulses=%0d expected 5", done_cnt);
        end
        n_checks++;
        if ({pend1, ovf1, busy1} !== 6'b0000_00) begin
            n_fail++;
            $display("FAIL burst_end: pend=%0d ovf=%b busy=%b expected 0 0 0", pend1, ovf1, busy1);
        end
        n_checks++;
        if (b2b_err != 0 || excl_err != 0) begin
            n_fail++;
            $display("FAIL burst_b2b: relaunch errors=%0d done-overlap errors=%0d expected 0 0", b2b_err, excl_err);
        end
        $display("test_burst: peak=%0d done pulses=%0d", max_pend, done_cnt);
    endtask

    task automatic test_saturate();
        ack2 = 1'b0; clr2 = 1'b0; ev2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 3) begin
                n_checks++;
                if ({pend2, ovf2} !== 3'b11_0) begin
                    n_fail++;
                    $display("FAIL sat_full: pend=%0d ovf=%b expected 3 0", pend2, ovf2);
                end
            end
        end
        ev2 = 1'b0;
        n_checks++;
        if ({pend2, ovf2, req2} !== 4'b11_1_1) begin
            n_fail++;
            $display("FAIL sat_overflow: pend=%0d ovf=%b req=%b expected 3 1 1", pend2, ovf2, req2);
        end
        ev2 = 1'b1; clr2 = 1'b1; step(); ev2 = 1'b0; clr2 = 1'b0;
        n_checks++;
        if ({pend2, ovf2} !== 3'b11_1) begin
            n_fail++;
            $display("FAIL sat_set_priority: pend=%0d ovf=%b expected 3 1", pend2, ovf2);
        end
        step();
        n_checks++;
        if (ovf2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_sticky: ovf=%b expected 1", ovf2);
        end
        clr2 = 1'b1; step(); clr2 = 1'b0;
        n_checks++;
        if ({pend2, ovf2} !== 3'b11_0) begin
            n_fail++;
            $display("FAIL sat_clear: pend=%0d ovf=%b expected 3 0", pend2, ovf2);
        end
        $display("test_saturate: pending=%0d overflow=%b", pend2, ovf2);
    endtask

    task automatic test_incdec();
        auto_ack = 1'b0; ack1 = 1'b0;
        ev1 = 1'b1; step(); step(); step(); ev1 = 1'b0;
        n_checks++;
        if ({req1, pend1} !== 5'b1_0010) begin
            n_fail++;
            $display("FAIL incdec_queue: req=%b pend=%0d expected 1 2", req1, pend1);
        end
        ack1 = 1'b1;
        for (int i = 0; i < 20 && req1; i++) step();
        ack1 = 1'b0;
        for (int i = 0; i < 20 && !done1; i++) step();
        n_checks++;
        if ({done1, busy1, pend1} !== 6'b10_0010) begin
            n_fail++;
            $display("FAIL incdec_done: done=%b busy=%b pend=%0d expected 1 0 2", done1, busy1, pend1);
        end
        ev1 = 1'b1; step(); ev1 = 1'b0;
        n_checks++;
        if ({req1, pend1} !== 5'b1_0010) begin
            n_fail++;
            $display("FAIL incdec_same_cycle: req=%b pend=%0d expected 1 2", req1, pend1);
        end
        done_cnt = 0; ack_cnt = 0; auto_ack = 1'b1;
        for (int i = 0; i < 300 && !(done_cnt == 3 && !busy1 && pend1 == 4'd0); i++) step();
        for (int i = 0; i < 5; i++) step();
        auto_ack = 1'b0;
        n_checks++;
        if (done_cnt != 3 || pend1 !== 4'd0 || b2b_err != 0) begin
            n_fail++;
            $display("FAIL incdec_drain: done pulses=%0d pend=%0d b2b errors=%0d expected 3 0 0", done_cnt, pend1, b2b_err);
        end
        $display("test_incdec: drained with %0d handshakes", done_cnt);
    endtask

    task automatic test_reset_mid();
        auto_ack = 1'b0; ack1 = 1'b0;
        ev1 = 1'b1; step(); ev1 = 1'b0;
        ack1 = 1'b1; step();
        n_checks++;
        if ({req1, busy1} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_in_flight: req/busy=%b expected 11", {req1, busy1});
        end
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req1, busy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_async_drop: req/busy=%b expected 00 before next edge", {req1, busy1});
        end
        step(); step();
        #2 reset_n = 1'b1;
        step(); step();
        ev1 = 1'b1; step(); ev1 = 1'b0;
        n_checks++;
        if ({req1, pend1} !== 5'b0_0001) begin
            n_fail++;
            $display("FAIL mid_stale_ack: req=%b pend=%0d expected 0 1", req1, pend1);
        end
        ack1 = 1'b0;
        step(); step();
        n_checks++;
        if (req1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_sync: req=%b expected 0 until ack low 2 edges", req1);
        end
        step();
        n_checks++;
        if ({req1, busy1, pend1} !== 6'b11_0000) begin
            n_fail++;
            $display("FAIL mid_relaunch: req=%b busy=%b pend=%0d expected 1 1 0", req1, busy1, pend1);
        end
        ack_cnt = 0; auto_ack = 1'b1;
        for (int i = 0; i < 100 && busy1; i++) step();
        auto_ack = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_complete: busy=%b expected 0 (handshake timeout)", busy1);
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        reset_n = 1'b0;
        ev1 = 1'b0; ack1 = 1'b0; clr1 = 1'b0;
        ev2 = 1'b0; ack2 = 1'b0; clr2 = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_saturate();
        test_incdec();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/event_handshake_sender.md
# event_handshake_sender

Source-side half of a four-phase req/ack clock-domain crossing. Accepts single-cycle event pulses in the local `clk` domain and delivers each one to a foreign domain as one full req/ack handshake, driving `req_out` as a level and taking the returning `ack_async` through an internal two-stage synchronizer. Events that arrive while a handshake is in flight are counted and replayed in order, so no pulse is lost until the counter saturates. It sits in front of the destination-side edge synchronizer, which sees each `req_out` rising edge as one event.

## Interface
- `CNT_W`, default 4: width of the pending-event counter; maximum backlog is 2^CNT_W − 1.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `event_in`  in  1  event pulse, synchronous to `clk`; each high cycle is one event.
- `ack_async`  in  1  acknowledge level from the foreign domain; asynchronous to `clk`.
- `req_out`  out  1  request level to the foreign domain; registered, glitch-free.
- `busy`  out  1  high while the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse when a handshake completes.
- `pending`  out  CNT_W  events queued but not yet launched.
- `overflow`  out  1  sticky; set when an event is dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Synchronizer: `ack_s1 <= ack_async`, `ack_s2 <= ack_s1`. Only `ack_s2` is used by the logic.
- FSM states and transitions:
  - IDLE → REQ_HIGH when (`event_in` or `pending != 0`) and `ack_s2 == 0`.
  - REQ_HIGH → REQ_LOW when `ack_s2 == 1`.
  - REQ_LOW → IDLE when `ack_s2 == 0`. `done` pulses high for the one cycle after this transition.
- `req_out` is a register set on entry to REQ_HIGH and cleared on entry to REQ_LOW.
- Launch source:
  - If `pending != 0`, the launch consumes one queued event.
  - Otherwise it consumes the `event_in` of the launch cycle, which is not counted.
- Counter update, per cycle:
  - inc = `event_in` and not (launch with `pending == 0`).
  - dec = launch with `pending != 0`.
  - inc and dec together: count unchanged.
  - inc alone at 2^CNT_W − 1: count holds, `overflow` sets, the event is dropped.
- `overflow`:
  - Set has priority over `clr_overflow` in the same cycle.
  - Otherwise `clr_overflow` clears it.
- IDLE with `ack_s2 == 1` (stale or violating ack): do not launch; events keep accumulating in `pending`.
- Reset mid-handshake: all state clears at once. `req_out` drops immediately, even if the foreign side still holds ack. The next launch waits in IDLE until `ack_s2 == 0`.

## Timing
- Reset values: state IDLE, `req_out` 0, `busy` 0, `done` 0, `pending` 0, `overflow` 0, `ack_s1` 0, `ack_s2` 0.
- Launch latency: `event_in` sampled at edge N in IDLE with `ack_s2 == 0` → `req_out` and `busy` high after edge N.
- Ack latency:
  - `ack_async` rises before edge E → `ack_s2` high after E+1 → `req_out` low after E+2.
  - The falling edge of `ack_async` takes the same path to IDLE and `done`.
- Back-to-back: from IDLE with `pending != 0`, `req_out` re-asserts on the edge after `done`'s cycle begins. `req_out` is low for at least one full cycle between handshakes.
- `done` is registered and is never high in the same cycle as a launch edge.

## Test plan
- Reset values: hold `reset_n` low, toggle `ack_async` and `event_in` → all outputs 0. Release reset → outputs stay 0 with no events.
- Single event, responder acks 3 cycles after `req_out`, drops ack 3 cycles after `req_out` falls:
  - `req_out` high 1 cycle after `event_in`.
  - `req_out` falls exactly 3 edges after ack rises.
  - One `done` pulse; `pending` stays 0.
- Burst of 5 consecutive `event_in` cycles, CNT_W=4:
  - `pending` peaks at 4.
  - 5 handshakes complete, 5 `done` pulses.
  - `pending` returns to 0; `overflow` stays 0.
- Saturation, CNT_W=2, ack withheld, 6 events:
  - `pending` = 3; `overflow` = 1.
  - `clr_overflow` on the same cycle as a dropped event → `overflow` stays 1. A later clear → 0.
- Simultaneous inc/dec: `pending` = 2, `event_in` on the launch cycle → `pending` stays 2 that cycle, then drains normally.
- Reset mid-REQ_HIGH with `ack_async` still high:
  - `req_out` drops asynchronously.
  - After reset, an event does not launch until `ack_async` has been low for 2 edges.
